ppu_entity_scheduler: RTL and testbench

Collects entity and dragon updates from up to three game-logic requesters and arbitrates them into a shadow slot file. At the start of vertical blanking it commits the whole shadow file to the active registers that drive the PictureProcessingUnit entity inputs. The PPU therefore never sees a slot change mid-frame, which prevents tearing. The block sits between the game logic and the PPU in the same 25 MHz pixel-clock domain.

---
 rtl/ppu_entity_scheduler_if.sv | 24 ++
 rtl/ppu_entity_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_ppu_entity_scheduler.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_entity_scheduler_if.sv
// Requester bus for the PPU entity scheduler. It carries three requesters packed side by side.
// Requester i owns slot bits [4i+3:4i] and data bits [18i+17:18i].
interface ppu_entity_scheduler_if;
   logic [2:0]  req_valid;
   logic [2:0]  req_ready;
   logic [11:0] req_slot;
   logic [53:0] req_data;

   // Game-logic side: drives requests and observes grants.
   modport master (
      output req_valid,
      output req_slot,
      output req_data,
      input  req_ready
   );

   // Scheduler side: observes requests and drives grants.
   modport slave (
      input  req_valid,
      input  req_slot,
      input  req_data,
      output req_ready
   );
endinterface

// File: rtl/ppu_entity_scheduler.sv
// PPU entity scheduler.
// Round-robin arbitration of slot writes from three requesters into a shadow file.
// At vblank start the whole shadow file is copied into the active registers that feed the PPU.
// Slot 15 is a CLEAR command. It resets the shadow file one slot per cycle. A commit requested
// while CLEAR is running is held back until the clear has finished.
module ppu_entity_scheduler #(
   parameter int          NUM_REQ     = 3,
   parameter logic [9:0]  VBLANK_LINE = 10'd480
) (
   input  logic                          clk_in,
   input  logic                          reset,
   ppu_entity_scheduler_if.slave         req_if,
   input  logic [9:0]                    counter_V,
   input  logic [9:0]                    counter_H,
   output logic [13:0]                   entity_1,
   output logic [13:0]                   entity_2,
   output logic [13:0]                   entity_3,
   output logic [13:0]                   entity_4,
   output logic [13:0]                   entity_5,
   output logic [13:0]                   entity_6,
   output logic [17:0]                   entity_7_Array,
   output logic [13:0]                   entity_8_Flip,
   output logic [14:0]                   dragon_1,
   output logic [14:0]                   dragon_2,
   output logic [14:0]                   dragon_3,
   output logic [14:0]                   dragon_4,
   output logic [14:0]                   dragon_5,
   output logic [14:0]                   dragon_6,
   output logic [14:0]                   dragon_7,
   output logic                          frame_commit,
   output logic                          busy
);

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_CLEAR  = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;
   localparam logic [3:0] SLOT_CLEAR = 4'd15;
   localparam logic [3:0] LAST_SLOT  = 4'd14;

   logic [1:0]  r_state;
   logic [1:0]  r_ptr;
   logic [3:0]  r_clr_idx;
   logic        r_pending;
   logic [9:0]  r_prev_v;

   logic [1:0]  w_next_state;
   logic [1:0]  w_next_ptr;
   logic [3:0]  w_next_clr_idx;
   logic        w_next_pending;

   logic [2:0]  w_grant;
   logic        w_gnt_any;
   logic [1:0]  w_gnt_idx;
   logic [3:0]  w_gnt_slot;
   logic [17:0] w_gnt_data;
   logic        w_gnt_write;
   logic        w_vblank;
   logic        w_load_active;
   logic        w_unused;

   // The horizontal counter is reserved and is not used yet.
   assign w_unused = ^counter_H;

   // Vblank start fires on the first cycle counter_V reaches the blanking line.
   assign w_vblank = (counter_V == VBLANK_LINE) && (r_prev_v != VBLANK_LINE);

   // Round-robin search from the pointer upward. The first valid requester wins.
   always_comb begin
      logic [2:0] idx;
      w_grant    = '0;
      w_gnt_any  = 1'b0;
      w_gnt_idx  = '0;
      w_gnt_slot = '0;
      w_gnt_data = '0;
      idx        = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = {1'b0, r_ptr} + 3'(k);
         if (idx >= 3'(NUM_REQ)) begin
            idx = idx - 3'(NUM_REQ);
         end
         if (!w_gnt_any && req_if.req_valid[idx[1:0]]) begin
            w_gnt_any          = 1'b1;
            w_gnt_idx          = idx[1:0];
            w_grant[idx[1:0]]  = 1'b1;
            w_gnt_slot         = req_if.req_slot[4*int'(idx) +: 4];
            w_gnt_data         = req_if.req_data[18*int'(idx) +: 18];
         end
      end
   end

   // Grants are offered only in RUN. CLEAR and COMMIT stall every requester.
   assign req_if.req_ready = (r_state == ST_RUN) ? w_grant : 3'b000;
   assign w_gnt_write      = (r_state == ST_RUN) && w_gnt_any && (w_gnt_slot != SLOT_CLEAR);

   // Next-state logic for the FSM, the round-robin pointer, the clear index and the pending commit.
   always_comb begin
      w_next_state   = r_state;
      w_next_ptr     = r_ptr;
      w_next_clr_idx = r_clr_idx;
      w_next_pending = r_pending;
      case (r_state)
         ST_RUN: begin
            if (w_gnt_any) begin
               w_next_ptr = (w_gnt_idx == 2'(NUM_REQ - 1)) ? 2'd0 : w_gnt_idx + 2'd1;
            end
            if (w_gnt_any && (w_gnt_slot == SLOT_CLEAR)) begin
               // A CLEAR wins over a simultaneous vblank. That commit waits for the clear.
               w_next_state   = ST_CLEAR;
               w_next_clr_idx = '0;
               w_next_pending = w_vblank;
            end else if (w_vblank) begin
               w_next_state = ST_COMMIT;
            end
         end
         ST_CLEAR: begin
            if (w_vblank) begin
               w_next_pending = 1'b1;
            end
            if (r_clr_idx == LAST_SLOT) begin
               w_next_clr_idx = '0;
               w_next_state   = (r_pending || w_vblank) ? ST_COMMIT : ST_RUN;
            end else begin
               w_next_clr_idx = r_clr_idx + 4'd1;
            end
         end
         ST_COMMIT: begin
            w_next_pending = 1'b0;
            w_next_state   = ST_RUN;
         end
         default: begin
            w_next_state   = ST_RUN;
            w_next_pending = 1'b0;
         end
      endcase
   end

   // The active file is loaded on the edge that enters COMMIT. frame_commit and the new values
   // therefore appear in the same cycle, and a write granted on that edge is included.
   assign w_load_active = (w_next_state == ST_COMMIT);

   // Control registers.
   // prev_V resets to the blanking line so that a counter parked at 480 does not fire a commit
   // right after reset.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         r_state   <= ST_RUN;
         r_ptr     <= '0;
         r_clr_idx <= '0;
         r_pending <= 1'b0;
         r_prev_v  <= VBLANK_LINE;
      end else begin
         r_state   <= w_next_state;
         r_ptr     <= w_next_ptr;
         r_clr_idx <= w_next_clr_idx;
         r_pending <= w_next_pending;
         r_prev_v  <= counter_V;
      end
   end

   assign frame_commit = (r_state == ST_COMMIT);
   assign busy         = (r_state != ST_RUN) || r_pending;

   // One shadow/active register pair per slot. Each register is sized to its slot's output width.
   for (genvar gi = 0; gi < 15; gi++) begin : g_slot
      localparam int          W     = (gi == 6) ? 18 : ((gi >= 8) ? 15 : 14);
      localparam logic [17:0] DEF18 = (gi == 6) ? 18'h3C000 : ((gi >= 8) ? 18'h07C00 : 18'h03C00);
      localparam logic [W-1:0] DEF  = DEF18[W-1:0];
      localparam logic [3:0]  SLOT  = 4'(gi);

      logic [W-1:0] r_shadow;
      logic [W-1:0] r_active;
      logic [W-1:0] w_shadow_next;

      // Shadow update: take a granted write to this slot, or take the default when the clear
      // index reaches this slot.
      always_comb begin
         w_shadow_next = r_shadow;
         if (w_gnt_write && (w_gnt_slot == SLOT)) begin
            w_shadow_next = w_gnt_data[W-1:0];
         end else if ((r_state == ST_CLEAR) && (r_clr_idx == SLOT)) begin
            w_shadow_next = DEF;
         end
      end

      // Shadow and active registers for this slot. The active register changes only on a commit.
      always_ff @(posedge clk_in) begin
         if (reset) begin
            r_shadow <= DEF;
            r_active <= DEF;
         end else begin
            r_shadow <= w_shadow_next;
            if (w_load_active) begin
               r_active <= w_shadow_next;
            end
         end
      end
   end

   assign entity_1       = g_slot[0].r_active;
   assign entity_2       = g_slot[1].r_active;
   assign entity_3       = g_slot[2].r_active;
   assign entity_4       = g_slot[3].r_active;
   assign entity_5       = g_slot[4].r_active;
   assign entity_6       = g_slot[5].r_active;
   assign entity_7_Array = g_slot[6].r_active;
   assign entity_8_Flip  = g_slot[7].r_active;
   assign dragon_1       = g_slot[8].r_active;
   assign dragon_2       = g_slot[9].r_active;
   assign dragon_3       = g_slot[10].r_active;
   assign dragon_4       = g_slot[11].r_active;
   assign dragon_5       = g_slot[12].r_active;
   assign dragon_6       = g_slot[13].r_active;
   assign dragon_7       = g_slot[14].r_active;

endmodule

// File: tb/tb_ppu_entity_scheduler.sv
// Directed bench for ppu_entity_scheduler. It covers reset, a single write, contention,
// a write on the vblank boundary, a deferred commit behind CLEAR, a held counter and a reset
// during CLEAR.
module tb_ppu_entity_scheduler;
   logic        clk_in;
   logic        reset;
   logic [9:0]  counter_V;
   logic [9:0]  counter_H;
   logic [13:0] entity_1, entity_2, entity_3, entity_4, entity_5, entity_6;
   logic [17:0] entity_7_Array;
   logic [13:0] entity_8_Flip;
   logic [14:0] dragon_1, dragon_2, dragon_3, dragon_4, dragon_5, dragon_6, dragon_7;
   logic        frame_commit;
   logic        busy;

   int n_assert = 0;
   int n_fail   = 0;
   int commits  = 0;

   ppu_entity_scheduler_if bus ();

   ppu_entity_scheduler #(.NUM_REQ(3), .VBLANK_LINE(10'd480)) dut (
      .clk_in         (clk_in),
      .reset          (reset),
      .req_if         (bus),
      .counter_V      (counter_V),
      .counter_H      (counter_H),
      .entity_1       (entity_1),
      .entity_2       (entity_2),
      .entity_3       (entity_3),
      .entity_4       (entity_4),
      .entity_5       (entity_5),
      .entity_6       (entity_6),
      .entity_7_Array (entity_7_Array),
      .entity_8_Flip  (entity_8_Flip),
      .dragon_1       (dragon_1),
      .dragon_2       (dragon_2),
      .dragon_3       (dragon_3),
      .dragon_4       (dragon_4),
      .dragon_5       (dragon_5),
      .dragon_6       (dragon_6),
      .dragon_7       (dragon_7),
      .frame_commit   (frame_commit),
      .busy           (busy)
   );

   // 25 MHz pixel clock.
   initial clk_in = 1'b0;
   always #20 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      reset         = 1'b1;
      bus.req_valid = '0;
      bus.req_slot  = '0;
      bus.req_data  = '0;
      counter_V     = '0;
      counter_H     = '0;

      // Reset state
      tick();
      tick();
      reset = 1'b0;
      #1;
      $display("[%0t] reset released", $time);
      check("rst_entity_1", 32'(entity_1), 32'h3C00);
      check("rst_entity_7", 32'(entity_7_Array), 32'h3C000);
      check("rst_dragon_3", 32'(dragon_3), 32'h7C00);
      check("rst_commit", 32'(frame_commit), 32'h0);
      check("rst_ready", 32'(bus.req_ready), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);

      // Single write: req0 writes slot 2 = 0A55, then a vblank occurs
      bus.req_valid = 3'b001;
      bus.req_slot  = 12'h002;
      bus.req_data  = {18'd0, 18'd0, 18'h00A55};
      #1;
      $display("[%0t] write req0 slot 2 data 0A55", $time);
      check("sw_ready", 32'(bus.req_ready), 32'h1);
      tick();
      bus.req_valid = '0;
      counter_V     = 10'd479;
      #1;
      check("sw_hold_e3", 32'(entity_3), 32'h3C00);
      check("sw_hold_fc", 32'(frame_commit), 32'h0);
      tick();
      counter_V = 10'd480;
      #1;
      check("sw_vb_e3", 32'(entity_3), 32'h3C00);
      check("sw_vb_fc", 32'(frame_commit), 32'h0);
      tick();
      $display("[%0t] commit after single write", $time);
      check("sw_commit_fc", 32'(frame_commit), 32'h1);
      check("sw_commit_e3", 32'(entity_3), 32'h0A55);
      check("sw_commit_busy", 32'(busy), 32'h1);
      tick();
      check("sw_post_fc", 32'(frame_commit), 32'h0);
      check("sw_post_e3", 32'(entity_3), 32'h0A55);
      counter_V = 10'd0;

      // Pointer is 1 now. A lone req2 write moves it back to 0.
      bus.req_valid = 3'b100;
      bus.req_slot  = {4'd3, 4'd0, 4'd0};
      bus.req_data  = {18'h00111, 18'd0, 18'd0};
      #1;
      $display("[%0t] write req2 slot 3 data 0111", $time);
      check("rr_ready_p1", 32'(bus.req_ready), 32'h4);
      tick();

      // Contention: all three requesters hold valid. req0's payload has bits above width 15.
      bus.req_valid = 3'b111;
      bus.req_slot  = {4'd10, 4'd9, 4'd8};
      bus.req_data  = {18'h00003, 18'h00002, 18'h38001};
      #1;
      $display("[%0t] contention slots 8 9 10", $time);
      check("ct_grant0", 32'(bus.req_ready), 32'h1);
      tick();
      check("ct_grant1", 32'(bus.req_ready), 32'h2);
      tick();
      check("ct_grant2", 32'(bus.req_ready), 32'h4);
      tick();
      bus.req_valid = '0;
      counter_V     = 10'd479;
      tick();
      counter_V = 10'd480;
      #1;
      check("ct_pre_d1", 32'(dragon_1), 32'h7C00);
      tick();
      $display("[%0t] commit after contention", $time);
      check("ct_fc", 32'(frame_commit), 32'h1);
      check("ct_d1", 32'(dragon_1), 32'h0001);
      check("ct_d2", 32'(dragon_2), 32'h0002);
      check("ct_d3", 32'(dragon_3), 32'h0003);
      check("ct_e4", 32'(entity_4), 32'h0111);
      tick();
      counter_V = 10'd0;
      tick();

      // Boundary write: req1 writes slot 7 in the same cycle as vblank start
      counter_V = 10'd479;
      tick();
      counter_V     = 10'd480;
      bus.req_valid = 3'b010;
      bus.req_slot  = {4'd0, 4'd7, 4'd0};
      bus.req_data  = {18'd0, 18'h01234, 18'd0};
      #1;
      $display("[%0t] write req1 slot 7 data 1234 at vblank", $time);
      check("bd_ready", 32'(bus.req_ready), 32'h2);
      tick();
      bus.req_valid = '0;
      #1;
      check("bd_fc", 32'(frame_commit), 32'h1);
      check("bd_e8", 32'(entity_8_Flip), 32'h1234);
      tick();
      counter_V = 10'd0;
      tick();

      // Deferred commit: CLEAR, then vblank during the clear
      bus.req_valid = 3'b001;
      bus.req_slot  = 12'h00F;
      bus.req_data  = '0;
      #1;
      $display("[%0t] clear command from req0", $time);
      check("df_ready_clr", 32'(bus.req_ready), 32'h1);
      tick();
      commits = 0;
      for (int i = 0; i < 15; i++) begin
         if (i == 3) counter_V = 10'd479;
         if (i == 5) counter_V = 10'd480;
         bus.req_valid = 3'b111;
         #1;
         check("df_clr_ready", 32'(bus.req_ready), 32'h0);
         check("df_clr_busy", 32'(busy), 32'h1);
         commits += int'(frame_commit);
         tick();
      end
      bus.req_valid = '0;
      #1;
      $display("[%0t] deferred commit", $time);
      check("df_fc", 32'(frame_commit), 32'h1);
      check("df_busy", 32'(busy), 32'h1);
      check("df_e3", 32'(entity_3), 32'h3C00);
      check("df_e4", 32'(entity_4), 32'h3C00);
      check("df_e7", 32'(entity_7_Array), 32'h3C000);
      check("df_e8", 32'(entity_8_Flip), 32'h3C00);
      check("df_d1", 32'(dragon_1), 32'h7C00);
      check("df_d3", 32'(dragon_3), 32'h7C00);
      commits += int'(frame_commit);
      tick();
      for (int i = 0; i < 3; i++) begin
         commits += int'(frame_commit);
         tick();
      end
      check("df_pulses", 32'(commits), 32'd1);
      check("df_idle_busy", 32'(busy), 32'h0);
      counter_V = 10'd0;
      tick();

      // Held counter: 480 for 20 clocks gives one commit
      counter_V = 10'd479;
      tick();
      commits = 0;
      for (int i = 0; i < 20; i++) begin
         counter_V = 10'd480;
         #1;
         commits += int'(frame_commit);
         tick();
      end
      counter_V = 10'd0;
      #1;
      commits += int'(frame_commit);
      $display("[%0t] held counter window done", $time);
      check("hc_pulses", 32'(commits), 32'd1);
      tick();

      // Reset during CLEAR at index 7, with a commit pending
      bus.req_valid = 3'b001;
      bus.req_slot  = 12'h000;
      bus.req_data  = {18'd0, 18'd0, 18'h00001};
      tick();
      bus.req_slot  = 12'h00F;
      tick();
      bus.req_valid = '0;
      for (int i = 0; i < 7; i++) begin
         if (i == 4) counter_V = 10'd479;
         if (i == 5) counter_V = 10'd480;
         tick();
      end
      #1;
      check("rc_busy_mid", 32'(busy), 32'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      $display("[%0t] reset during clear", $time);
      check("rc_busy", 32'(busy), 32'h0);
      check("rc_fc", 32'(frame_commit), 32'h0);
      commits = 0;
      for (int i = 0; i < 20; i++) begin
         commits += int'(frame_commit);
         tick();
      end
      check("rc_pulses", 32'(commits), 32'd0);
      check("rc_e1", 32'(entity_1), 32'h3C00);
      check("rc_e3", 32'(entity_3), 32'h3C00);
      check("rc_e7", 32'(entity_7_Array), 32'h3C000);
      check("rc_e8", 32'(entity_8_Flip), 32'h3C00);
      check("rc_d1", 32'(dragon_1), 32'h7C00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
